// File: rtl/seq_divider_16by8.sv
// 16-bit by 8-bit unsigned restoring divider that resolves one quotient bit per clock.
// A start/busy/done handshake controls it, and divide-by-zero is flagged explicitly.
module seq_divider_16by8 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] work_q, work_d;
   logic [7:0]  dvsr_q, dvsr_d;
   logic [7:0]  pr_q, pr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] quot_q, quot_d;
   logic [7:0]  rem_q, rem_d;
   logic        dbz_q, dbz_d;

   logic [8:0]  pr_shift;
   logic [8:0]  trial;
   logic [7:0]  pr_next;
   logic [15:0] work_next;

   // The kept partial remainder is always below the divisor, so 8 stored bits suffice;
   // only the shifted value and the trial difference need the ninth bit.
   always_comb begin
      pr_shift  = {pr_q, work_q[15]};
      trial     = pr_shift - {1'b0, dvsr_q};
      pr_next   = trial[8] ? pr_shift[7:0] : trial[7:0];
      work_next = {work_q[14:0], ~trial[8]};
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      dvsr_d  = dvsr_q;
      pr_d    = pr_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == 8'd0) begin
                  quot_d  = 16'hFFFF;
                  rem_d   = dividend[7:0];
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  work_d  = dividend;
                  dvsr_d  = divisor;
                  pr_d    = 8'd0;
                  cnt_d   = 4'd0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            work_d = work_next;
            pr_d   = pr_next;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               quot_d  = work_next;
               rem_d   = pr_next;
               dbz_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= 16'd0;
         dvsr_q  <= 8'd0;
         pr_q    <= 8'd0;
         cnt_q   <= 4'd0;
         quot_q  <= 16'd0;
         rem_q   <= 8'd0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         dvsr_q  <= dvsr_d;
         pr_q    <= pr_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed bench for seq_divider_16by8: latency, results, divide-by-zero,
// held start, mid-run reset and a short batch of random operands.
module tb_seq_divider_16by8;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider_16by8 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete operation from an idle divider; checks latency, busy, stability and results.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic ez);
      int          n;
      logic        stable;
      logic [15:0] qprev;
      logic [7:0]  rprev;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      qprev    = quotient;
      rprev    = remainder;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = ~a;
      divisor  = b + 8'd3;
      check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
      n      = 0;
      stable = 1'b1;
      while (!done && n < 40) begin
         if (quotient !== qprev || remainder !== rprev || !busy) stable = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, n, (b == 8'd0) ? 32'd0 : 32'd16);
      check({tag, "_stable_in_run"}, {31'd0, stable}, 32'd1);
      check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
      check({tag, "_remainder"}, {24'd0, remainder}, {24'd0, er});
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
      @(posedge clk);
      #1;
      check({tag, "_done_pulse_end"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      logic [15:0] ra, a0, a1, cur_a;
      logic [7:0]  rb, b0, b1, cur_b;
      logic        idle_before, saw_done;
      int          second_edge, ndone;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = 16'd0;
      divisor  = 8'd0;
      #1;
      check("reset_outputs", {quotient, remainder, busy, done, div_by_zero}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      do_op("d1000_7", 16'd1000, 8'd7, 16'h008E, 8'd6, 1'b0);
      do_op("dFFFF_FF", 16'hFFFF, 8'hFF, 16'h0101, 8'd0, 1'b0);
      do_op("dFFFF_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0);
      do_op("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
      do_op("d0_3", 16'd0, 8'd3, 16'd0, 8'd0, 1'b0);
      do_op("d1234_0", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1);
      do_op("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0);
      do_op("d0_255", 16'd0, 8'd255, 16'd0, 8'd0, 1'b0);
      do_op("dFFFF_0", 16'hFFFF, 8'd0, 16'hFFFF, 8'hFF, 1'b1);
      do_op("d254_255", 16'd254, 8'd255, 16'd0, 8'd254, 1'b0);

      // Held start with operands changing every cycle.
      @(negedge clk);
      a0 = 16'd1000; b0 = 8'd7;
      dividend = a0; divisor = b0; start = 1'b1;
      @(posedge clk);
      #1;
      second_edge = -1;
      ndone       = 0;
      a1 = 16'd0; b1 = 8'd1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         cur_a       = 16'($urandom);
         cur_b       = 8'($urandom_range(1, 255));
         dividend    = cur_a;
         divisor     = cur_b;
         idle_before = !busy;
         @(posedge clk);
         #1;
         if (idle_before && busy && second_edge < 0) begin
            second_edge = k;
            a1 = cur_a;
            b1 = cur_b;
         end
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               check("held_first_q", {16'd0, quotient}, {16'd0, a0 / {8'd0, b0}});
               check("held_first_r", {24'd0, remainder}, {24'd0, 8'(a0 % {8'd0, b0})});
            end else if (ndone == 2) begin
               check("held_second_q", {16'd0, quotient}, {16'd0, a1 / {8'd0, b1}});
               check("held_second_r", {24'd0, remainder}, {24'd0, 8'(a1 % {8'd0, b1})});
            end
         end
      end
      check("held_second_accept_edge", second_edge, 32'd18);
      check("held_done_count", ndone, 32'd2);
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("held_back_idle", {31'd0, busy}, 32'd0);

      // Reset at the 8th RUN edge of 300/7.
      @(negedge clk);
      dividend = 16'd300; divisor = 8'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("abort_busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_outputs_zero", {quotient, remainder, busy, done, div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1'b1;
      end
      check("abort_no_done", {31'd0, saw_done}, 32'd0);
      do_op("d300_7", 16'd300, 8'd7, 16'd42, 8'd6, 1'b0);

      // Random operands against the arithmetic reference.
      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom);
         rb = (i % 5 == 0) ? 8'd1 : 8'($urandom_range(1, 255));
         do_op("rand", ra, rb, ra / {8'd0, rb}, 8'(ra % {8'd0, rb}), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
